seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/div_pkg.sv | 16 +
 rtl/div_step.sv | 21 ++
 rtl/seq_divider.sv | 127 ++++++++++++
 tb/tb_seq_divider.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM states,
// default operand width and the quotient returned on divide-by-zero.
package div_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int MAX_WIDTH = 64;

  // Quotient reported for a zero divisor; sliced down to the operand width.
  localparam logic [MAX_WIDTH-1:0] DZ_QUO = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } div_state_t;
endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step on a {rem,quo} pair.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_n,
  output logic [WIDTH-1:0] quo_n
);
  logic [WIDTH:0]   wide;
  logic [WIDTH-1:0] diff;
  logic             fits;

  // The shifted partial remainder needs one extra bit before the compare.
  assign wide  = {rem, quo[WIDTH-1]};
  assign fits  = (wide >= {1'b0, dvs});
  assign diff  = wide[WIDTH-1:0] - dvs;
  assign rem_n = fits ? diff : wide[WIDTH-1:0];
  assign quo_n = {quo[WIDTH-2:0], fits};
endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per cycle.
// Signed operation is built only with SEQ_DIVIDER_SIGNED_EN defined.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic             SIGNED,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             DZ,
  output logic             OF
);
  localparam int CW = $clog2(WIDTH) + 1;

  div_state_t       state, nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem, quo, dvs;
  logic [WIDTH-1:0] rem_n, quo_n;
  logic             qneg, rneg, skip;
  logic [WIDTH-1:0] q_r, r_r;
  logic             dz_r, of_r;

  logic             a_neg, b_neg, b_zero, ovf;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign b_zero = (B == '0);

`ifdef SEQ_DIVIDER_SIGNED_EN
  assign a_neg = SIGNED & A[WIDTH-1];
  assign b_neg = SIGNED & B[WIDTH-1];
  assign a_mag = a_neg ? -A : A;
  assign b_mag = b_neg ? -B : B;
  assign ovf   = SIGNED && (A == {1'b1, {(WIDTH-1){1'b0}}}) && (&B);
`else
  logic sgn_unused;
  assign sgn_unused = SIGNED;
  assign a_neg = 1'b0;
  assign b_neg = 1'b0;
  assign a_mag = A;
  assign b_mag = B;
  assign ovf   = 1'b0;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem   (rem),
    .quo   (quo),
    .dvs   (dvs),
    .rem_n (rem_n),
    .quo_n (quo_n)
  );

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: if (START) nxt = (b_zero || ovf) ? S_FIX : S_CALC;
      S_CALC: if (cnt == CW'(WIDTH-1)) nxt = S_FIX;
      S_FIX:  nxt = S_DONE;
      S_DONE: nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= S_IDLE;
      cnt   <= '0;
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
      qneg  <= 1'b0;
      rneg  <= 1'b0;
      skip  <= 1'b0;
      q_r   <= '0;
      r_r   <= '0;
      dz_r  <= 1'b0;
      of_r  <= 1'b0;
    end else begin
      state <= nxt;
      case (state)
        S_IDLE: if (START) begin
          cnt  <= '0;
          rem  <= '0;
          quo  <= a_mag;
          dvs  <= b_mag;
          qneg <= a_neg ^ b_neg;
          rneg <= a_neg;
          skip <= b_zero | ovf;
          dz_r <= b_zero;
          of_r <= ovf & ~b_zero;
          // Special cases bypass CALC, so their results are loaded here.
          if (b_zero) begin
            q_r <= DZ_QUO[WIDTH-1:0];
            r_r <= A;
          end else if (ovf) begin
            q_r <= A;
            r_r <= '0;
          end
        end
        S_CALC: begin
          rem <= rem_n;
          quo <= quo_n;
          cnt <= cnt + 1'b1;
        end
        S_FIX: if (!skip) begin
          q_r <= qneg ? -quo : quo;
          r_r <= rneg ? -rem : rem;
        end
        default: ;
      endcase
    end
  end

  assign BUSY = (state == S_CALC) || (state == S_FIX);
  assign DONE = (state == S_DONE);
  assign Q    = q_r;
  assign R    = r_r;
  assign DZ   = dz_r;
  assign OF   = of_r;
endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed corner cases plus random
// operands checked against a plain-arithmetic reference model.
module tb_seq_divider;
  localparam int W = 32;
  localparam int NORM_LAT = W + 2;
  localparam int SPEC_LAT = 2;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b0;
  logic         START = 1'b0;
  logic         SIGNED = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         BUSY, DONE, DZ, OF;
  logic [W-1:0] Q, R;

  int checks = 0;
  int errors = 0;

  seq_divider #(.WIDTH(W)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .SIGNED(SIGNED),
    .A(A), .B(B), .BUSY(BUSY), .DONE(DONE), .Q(Q), .R(R), .DZ(DZ), .OF(OF)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: division as defined arithmetically, truncating toward zero.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       output logic [W-1:0] q, output logic [W-1:0] r,
                       output logic dz, output logic of, output int lat);
    logic ss;
`ifdef SEQ_DIVIDER_SIGNED_EN
    ss = s;
`else
    ss = 1'b0;
`endif
    dz = 1'b0; of = 1'b0; lat = NORM_LAT;
    if (b == 0) begin
      q = '1; r = a; dz = 1'b1; lat = SPEC_LAT;
    end else if (ss && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a; r = '0; of = 1'b1; lat = SPEC_LAT;
    end else if (ss) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  // Runs one division; inj > 0 re-asserts START (50/5) at that cycle count.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input int inj, input string tag);
    logic [W-1:0] eq, er;
    logic edz, eof;
    int elat, lat;
    model(a, b, s, eq, er, edz, eof, elat);
    @(negedge CLK);
    START = 1'b1; A = a; B = b; SIGNED = s;
    @(negedge CLK);
    START = 1'b0;
    lat = 1;
    chk({tag, "_busy"}, W'(BUSY), W'(1));
    while (!DONE && lat < 200) begin
      START = (lat == inj);
      if (lat == inj) begin A = 50; B = 5; SIGNED = 1'b0; end
      @(negedge CLK);
      lat++;
    end
    chk({tag, "_lat"}, W'(lat), W'(elat));
    chk({tag, "_q"}, Q, eq);
    chk({tag, "_r"}, R, er);
    chk({tag, "_dz"}, W'(DZ), W'(edz));
    chk({tag, "_of"}, W'(OF), W'(eof));
    // START during the DONE cycle must not be accepted.
    START = 1'b1; A = $urandom; B = 1; SIGNED = 1'b0;
    @(negedge CLK);
    START = 1'b0;
    chk({tag, "_pulse"}, W'({DONE, BUSY}), W'(0));
    chk({tag, "_hold"}, Q, eq);
  endtask

  initial begin
    int lat, ndone;
    logic [W-1:0] ra, rb;
    logic rs;
    repeat (2) @(negedge CLK);
    chk("rst_ctl", W'({BUSY, DONE, DZ, OF}), W'(0));
    chk("rst_q", Q, '0);
    chk("rst_r", R, '0);
    RST_N = 1'b1;

    run_op(100, 7, 1'b0, 0, "u100_7");
    run_op(32'hFFFF_FFF9, 2, 1'b1, 0, "s_m7_2");
    run_op(32'h1234_5678, 0, 1'b0, 0, "dz");
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, "ovf");
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, "u_big");
    run_op(100, 7, 1'b0, 10, "ignore");
    run_op(32'hFFFF_FFFF, 1, 1'b0, 0, "u_max");
    run_op(5, 32'hFFFF_FFFF, 1'b0, 0, "u_smalldiv");
    run_op(32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 0, "s_neg_neg");

    // Reset partway through an operation.
    @(negedge CLK);
    START = 1'b1; A = 100; B = 7; SIGNED = 1'b0;
    @(negedge CLK);
    START = 1'b0;
    lat = 1;
    while (lat < 15) begin @(negedge CLK); lat++; end
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    chk("midrst_ctl", W'({BUSY, DONE, DZ, OF}), W'(0));
    chk("midrst_q", Q, '0);
    chk("midrst_r", R, '0);
    ndone = 0;
    repeat (40) begin @(negedge CLK); if (DONE) ndone++; end
    chk("midrst_nodone", W'(ndone), W'(0));
    run_op(9, 3, 1'b0, 0, "after_rst");

    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      case (i % 4)
        0: rb = $urandom;
        1: rb = W'($urandom_range(1, 300));
        2: rb = (i % 8 == 2) ? '0 : -W'($urandom_range(1, 50));
        default: rb = $urandom >> $urandom_range(0, 31);
      endcase
      rs = $urandom_range(0, 1);
      run_op(ra, rb, rs, 0, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
